// File: rtl/vending_fsm_param.sv
// -----------------------------------------------------------------------------
// vending_fsm_param
// Parametrised vending-machine controller. It accumulates credit from three
// coin denominations and checks a selection against a per-product price table.
// A successful selection produces a one-cycle vend strobe, and any remaining
// credit is then paid back one unit per tick. Cancel and an inactivity timeout
// both trigger a full refund. Runs on a single clock, with `tick` as the slow
// pacing enable.
//
// Ports
//   clk              system clock, rising edge
//   rst_n            asynchronous active-low reset
//   tick             one-cycle enable pacing change payout and timeout
//   coin/coin_valid  denomination code (00 none, 01=1, 10=2, 11=5) + strobe
//   sel/sel_valid    product index + strobe
//   cancel           refund request
//   vend_valid       one-cycle dispense strobe; vend_prod is the product
//   change_pulse     one-cycle pulse per unit of credit returned
//   coin_reject      one-cycle pulse, coin not accepted
//   err_insufficient one-cycle pulse, selection refused
//   credit           current credit
//   busy             high while vending or paying change
// -----------------------------------------------------------------------------
module vending_fsm_param #(
  parameter int N_PROD        = 4,
  parameter int CREDIT_W      = 5,
  parameter int MAX_CREDIT    = 20,
  parameter logic [N_PROD*CREDIT_W-1:0] PRICES = {5'd10, 5'd8, 5'd6, 5'd4},
  parameter int TIMEOUT_TICKS = 15,
  localparam int SEL_W        = $clog2(N_PROD)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                tick,
  input  logic [1:0]          coin,
  input  logic                coin_valid,
  input  logic [SEL_W-1:0]    sel,
  input  logic                sel_valid,
  input  logic                cancel,
  output logic                vend_valid,
  output logic [SEL_W-1:0]    vend_prod,
  output logic                change_pulse,
  output logic                coin_reject,
  output logic                err_insufficient,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_VEND   = 2'd2,
    ST_CHANGE = 2'd3
  } state_t;

  state_t              r_state, w_state_next;
  logic [CREDIT_W-1:0] r_credit, w_credit_next;
  logic [7:0]          r_tmo, w_tmo_next;
  logic [SEL_W-1:0]    r_vend_prod, w_vend_prod_next;
  logic                r_vend_valid, w_vend_valid_next;
  logic                r_change_pulse, w_change_pulse_next;
  logic                r_coin_reject, w_coin_reject_next;
  logic                r_err, w_err_next;
  logic                r_busy, w_busy_next;

  // Price table unpacked from the flat parameter vector.
  logic [CREDIT_W-1:0] w_price_tab [N_PROD];
  genvar gi;
  generate
    for (gi = 0; gi < N_PROD; gi++) begin : g_price
      assign w_price_tab[gi] = PRICES[gi*CREDIT_W +: CREDIT_W];
    end
  endgenerate

  logic                w_sel_ok;
  logic [CREDIT_W-1:0] w_price;
  logic                w_coin_present;
  logic [CREDIT_W-1:0] w_coin_val;
  logic [CREDIT_W:0]   w_sum;
  logic                w_coin_fits;

  // With a non-power-of-two N_PROD the select field can encode missing products.
  assign w_sel_ok = (32'(sel) < N_PROD);
  assign w_price  = w_sel_ok ? w_price_tab[sel] : '0;

  assign w_coin_present = coin_valid && (coin != 2'b00);

  always_comb begin
    w_coin_val = '0;
    case (coin)
      2'b01:   w_coin_val = CREDIT_W'(1);
      2'b10:   w_coin_val = CREDIT_W'(2);
      2'b11:   w_coin_val = CREDIT_W'(5);
      default: w_coin_val = '0;
    endcase
  end

  // One extra bit so an over-ceiling sum is detected rather than wrapped.
  assign w_sum       = {1'b0, r_credit} + {1'b0, w_coin_val};
  assign w_coin_fits = (w_sum <= (CREDIT_W+1)'(MAX_CREDIT));

  always_comb begin
    w_state_next        = r_state;
    w_credit_next       = r_credit;
    w_tmo_next          = r_tmo;
    w_vend_prod_next    = r_vend_prod;
    w_vend_valid_next   = 1'b0;
    w_change_pulse_next = 1'b0;
    w_coin_reject_next  = 1'b0;
    w_err_next          = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_coin_present) begin
          w_credit_next = w_coin_val;
          w_tmo_next    = '0;
          w_state_next  = ST_CREDIT;
        end
      end

      ST_CREDIT: begin
        // Priority cancel > selection > coin; losers are dropped silently.
        if (cancel) begin
          w_tmo_next   = '0;
          w_state_next = ST_CHANGE;
        end else if (sel_valid) begin
          w_tmo_next = '0;
          if (!w_sel_ok || (r_credit < w_price)) begin
            w_err_next = 1'b1;
          end else begin
            w_credit_next     = r_credit - w_price;
            w_vend_prod_next  = sel;
            w_vend_valid_next = 1'b1;
            w_state_next      = ST_VEND;
          end
        end else if (w_coin_present && w_coin_fits) begin
          w_credit_next = w_sum[CREDIT_W-1:0];
          w_tmo_next    = '0;
        end else begin
          if (w_coin_present) begin
            w_coin_reject_next = 1'b1;
          end
          if (tick) begin
            if (r_tmo == 8'(TIMEOUT_TICKS - 1)) begin
              w_tmo_next   = '0;
              w_state_next = ST_CHANGE;
            end else begin
              w_tmo_next = r_tmo + 8'd1;
            end
          end
        end
      end

      ST_VEND: begin
        w_state_next = (r_credit != '0) ? ST_CHANGE : ST_IDLE;
      end

      ST_CHANGE: begin
        if (w_coin_present) begin
          w_coin_reject_next = 1'b1;
        end
        if (r_credit == '0) begin
          w_state_next = ST_IDLE;
        end else if (tick) begin
          w_credit_next       = r_credit - CREDIT_W'(1);
          w_change_pulse_next = 1'b1;
          if (r_credit == CREDIT_W'(1)) begin
            w_state_next = ST_IDLE;
          end
        end
      end

      default: w_state_next = ST_IDLE;
    endcase

    w_busy_next = (w_state_next == ST_VEND) || (w_state_next == ST_CHANGE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_credit       <= '0;
      r_tmo          <= '0;
      r_vend_prod    <= '0;
      r_vend_valid   <= 1'b0;
      r_change_pulse <= 1'b0;
      r_coin_reject  <= 1'b0;
      r_err          <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_credit       <= w_credit_next;
      r_tmo          <= w_tmo_next;
      r_vend_prod    <= w_vend_prod_next;
      r_vend_valid   <= w_vend_valid_next;
      r_change_pulse <= w_change_pulse_next;
      r_coin_reject  <= w_coin_reject_next;
      r_err          <= w_err_next;
      r_busy         <= w_busy_next;
    end
  end

  assign vend_valid       = r_vend_valid;
  assign vend_prod        = r_vend_prod;
  assign change_pulse     = r_change_pulse;
  assign coin_reject      = r_coin_reject;
  assign err_insufficient = r_err;
  assign credit           = r_credit;
  assign busy             = r_busy;

endmodule

// File: tb/tb_vending_fsm_param.sv
// -----------------------------------------------------------------------------
// tb_vending_fsm_param
// Scenario tasks drive stimulus and push the pulse events they expect into a
// queue; a negedge monitor pops and compares every pulse the DUT produces.
// Credit/busy/strobe levels are compared inline within each task.
// Event codes: 1 err_insufficient, 2 coin_reject, 3 change_pulse, 16+p vend p.
// -----------------------------------------------------------------------------
module tb_vending_fsm_param;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] coin = 2'b00;
  logic       coin_valid = 1'b0;
  logic [1:0] sel = 2'b00;
  logic       sel_valid = 1'b0;
  logic       cancel = 1'b0;
  logic       vend_valid;
  logic [1:0] vend_prod;
  logic       change_pulse;
  logic       coin_reject;
  logic       err_insufficient;
  logic [4:0] credit;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;
  int exp_q[$];

  localparam int EV_ERR = 1, EV_REJ = 2, EV_CHG = 3, EV_VEND = 16;

  vending_fsm_param dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .coin(coin), .coin_valid(coin_valid),
    .sel(sel), .sel_valid(sel_valid), .cancel(cancel),
    .vend_valid(vend_valid), .vend_prod(vend_prod),
    .change_pulse(change_pulse), .coin_reject(coin_reject),
    .err_insufficient(err_insufficient),
    .credit(credit), .busy(busy)
  );

  always #5 clk = ~clk;

  // Pulse monitor / scoreboard consumer.
  logic m_hit;
  int   m_code;
  int   m_exp;
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 4; k++) begin
        m_hit  = 1'b0;
        m_code = 0;
        case (k)
          0: begin m_hit = vend_valid;       m_code = EV_VEND + int'(vend_prod); end
          1: begin m_hit = err_insufficient; m_code = EV_ERR; end
          2: begin m_hit = coin_reject;      m_code = EV_REJ; end
          default: begin m_hit = change_pulse; m_code = EV_CHG; end
        endcase
        if (m_hit) begin
          vectors++;
          if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL pulse_event: got event %0d expected none at %0t", m_code, $time);
          end else begin
            m_exp = exp_q.pop_front();
            $display("event %0d expected %0d at %0t", m_code, m_exp, $time);
            if (m_code != m_exp) begin
              miscompares++;
              $display("FAIL pulse_event: got event %0d expected %0d at %0t", m_code, m_exp, $time);
            end
          end
        end
      end
    end
  end

  // ---------------- stimulus primitives ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put_coin(input logic [1:0] c);
    coin = c; coin_valid = 1'b1;
    step();
    coin = 2'b00; coin_valid = 1'b0;
  endtask

  task automatic do_sel(input logic [1:0] s);
    sel = s; sel_valid = 1'b1;
    step();
    sel_valid = 1'b0;
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    step();
    cancel = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  // Expects n refund pulses, ticks until idle (bounded), then checks end state.
  task automatic drain(input int n, input string name);
    int guard;
    for (int i = 0; i < n; i++) exp_q.push_back(EV_CHG);
    guard = 0;
    while (busy && guard < n + 4) begin
      do_tick();
      guard++;
    end
    @(negedge clk); #1;
    vectors++;
    if (busy !== 1'b0 || credit !== 5'd0) begin
      miscompares++;
      $display("FAIL %s_end: got busy=%0d credit=%0d expected busy=0 credit=0", name, busy, credit);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_pending: got %0d missing events expected 0", name, exp_q.size());
      exp_q.delete();
    end
    $display("%s: drain of %0d done in %0d ticks", name, n, guard);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    vectors++;
    if ({vend_valid, vend_prod, change_pulse, coin_reject, err_insufficient, credit, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got credit=%0d busy=%0d vend=%0d expected all 0", credit, busy, vend_valid);
    end
    #2 rst_n = 1'b1;
    step();
    $display("test_reset: credit=%0d busy=%0d", credit, busy);
  endtask

  task automatic test_vend_change();
    put_coin(2'b11);
    put_coin(2'b10);
    vectors++;
    if (credit !== 5'd7) begin
      miscompares++;
      $display("FAIL vend_credit7: got %0d expected 7", credit);
    end
    exp_q.push_back(EV_VEND + 1);
    do_sel(2'd1);
    vectors++;
    if (vend_valid !== 1'b1 || vend_prod !== 2'd1 || credit !== 5'd1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL vend_strobe: got v=%0d p=%0d credit=%0d busy=%0d expected v=1 p=1 credit=1 busy=1",
               vend_valid, vend_prod, credit, busy);
    end
    step();
    vectors++;
    if (vend_valid !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL vend_one_cycle: got v=%0d busy=%0d expected v=0 busy=1", vend_valid, busy);
    end
    drain(1, "vend_change");
  endtask

  task automatic test_timeout();
    put_coin(2'b10);
    repeat (14) do_tick();
    vectors++;
    if (busy !== 1'b0 || credit !== 5'd2) begin
      miscompares++;
      $display("FAIL timeout_early: got busy=%0d credit=%0d expected busy=0 credit=2", busy, credit);
    end
    do_tick();
    vectors++;
    if (busy !== 1'b1 || credit !== 5'd2 || change_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL timeout_fire: got busy=%0d credit=%0d chg=%0d expected busy=1 credit=2 chg=0",
               busy, credit, change_pulse);
    end
    drain(2, "timeout");
  endtask

  task automatic test_reject();
    put_coin(2'b11); put_coin(2'b11); put_coin(2'b11);
    put_coin(2'b10); put_coin(2'b01);
    vectors++;
    if (credit !== 5'd18) begin
      miscompares++;
      $display("FAIL reject_credit18: got %0d expected 18", credit);
    end
    exp_q.push_back(EV_REJ);
    put_coin(2'b11);
    vectors++;
    if (credit !== 5'd18 || coin_reject !== 1'b1) begin
      miscompares++;
      $display("FAIL reject_over: got credit=%0d rej=%0d expected credit=18 rej=1", credit, coin_reject);
    end
    put_coin(2'b10);
    vectors++;
    if (credit !== 5'd20 || coin_reject !== 1'b0) begin
      miscompares++;
      $display("FAIL reject_ceiling: got credit=%0d rej=%0d expected credit=20 rej=0", credit, coin_reject);
    end
    exp_q.push_back(EV_REJ);
    put_coin(2'b01);
    vectors++;
    if (credit !== 5'd20) begin
      miscompares++;
      $display("FAIL reject_at_max: got %0d expected 20", credit);
    end
    do_cancel();
    drain(20, "reject");
  endtask

  task automatic test_insufficient();
    put_coin(2'b10); put_coin(2'b01);
    exp_q.push_back(EV_ERR);
    do_sel(2'd0);
    vectors++;
    if (err_insufficient !== 1'b1 || vend_valid !== 1'b0 || busy !== 1'b0 || credit !== 5'd3) begin
      miscompares++;
      $display("FAIL insuff_refuse: got err=%0d v=%0d busy=%0d credit=%0d expected err=1 v=0 busy=0 credit=3",
               err_insufficient, vend_valid, busy, credit);
    end
    put_coin(2'b11); put_coin(2'b10);
    exp_q.push_back(EV_VEND + 3);
    do_sel(2'd3);
    vectors++;
    if (vend_valid !== 1'b1 || vend_prod !== 2'd3 || credit !== 5'd0) begin
      miscompares++;
      $display("FAIL insuff_exact: got v=%0d p=%0d credit=%0d expected v=1 p=3 credit=0",
               vend_valid, vend_prod, credit);
    end
    step();
    vectors++;
    if (busy !== 1'b0 || change_pulse !== 1'b0) begin
      miscompares++;
      $display("FAIL insuff_idle: got busy=%0d chg=%0d expected busy=0 chg=0", busy, change_pulse);
    end
    drain(0, "insufficient");
  endtask

  task automatic test_cancel_priority();
    put_coin(2'b11); put_coin(2'b10); put_coin(2'b10);
    cancel = 1'b1; sel = 2'd0; sel_valid = 1'b1;
    step();
    cancel = 1'b0; sel_valid = 1'b0;
    vectors++;
    if (vend_valid !== 1'b0 || busy !== 1'b1 || credit !== 5'd9) begin
      miscompares++;
      $display("FAIL cancel_wins: got v=%0d busy=%0d credit=%0d expected v=0 busy=1 credit=9",
               vend_valid, busy, credit);
    end
    drain(9, "cancel_priority");
  endtask

  task automatic test_back_to_back();
    put_coin(2'b01); put_coin(2'b01); put_coin(2'b01);
    vectors++;
    if (credit !== 5'd3) begin
      miscompares++;
      $display("FAIL b2b_credit: got %0d expected 3", credit);
    end
    do_cancel();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(EV_REJ);
      put_coin(2'b11);
      vectors++;
      if (coin_reject !== 1'b1 || credit !== 5'd3) begin
        miscompares++;
        $display("FAIL b2b_reject%0d: got rej=%0d credit=%0d expected rej=1 credit=3", i, coin_reject, credit);
      end
    end
    drain(3, "back_to_back");
  endtask

  task automatic test_reset_mid();
    put_coin(2'b11); put_coin(2'b10);
    do_cancel();
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(EV_CHG);
      do_tick();
    end
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({vend_valid, vend_prod, change_pulse, coin_reject, err_insufficient, credit, busy} !== '0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: got chg=%0d credit=%0d busy=%0d expected all 0",
               change_pulse, credit, busy);
    end
    step();
    rst_n = 1'b1;
    repeat (6) do_tick();
    @(negedge clk); #1;
    vectors++;
    if (credit !== 5'd0 || busy !== 1'b0 || exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL reset_mid_after: got credit=%0d busy=%0d pending=%0d expected 0 0 0",
               credit, busy, exp_q.size());
    end
    $display("test_reset_mid: credit=%0d busy=%0d", credit, busy);
  endtask

  initial begin
    test_reset();
    test_vend_change();
    test_timeout();
    test_reject();
    test_insufficient();
    test_cancel_priority();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
